// File: rtl/sr_latch_writer.sv
// sr_latch_writer: writes a masked word into a gated SR latch bank with a timed E pulse, then verifies Q read-back.
module sr_latch_writer #(
    parameter int WIDTH   = 8,
    parameter int E_PULSE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] wmask,
    input  logic [WIDTH-1:0] q_in,
    output logic             ready,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] R,
    output logic             E,
    output logic             done,
    output logic             err
);
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d, m_q, m_d, s_q, s_d, r_q, r_d;
    logic ready_q, ready_d, e_q, e_d, done_q, done_d, err_q, err_d, drive;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        m_d     = m_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE:  if (req) begin
                state_d = SETUP;
                d_d     = wdata;
                m_d     = wmask;
            end
            SETUP: begin
                state_d = PULSE;
                cnt_d   = 4'(E_PULSE - 1);
            end
            PULSE: begin
                state_d = (cnt_q == 4'd0) ? HOLD : PULSE;
                cnt_d   = cnt_q - 4'd1;
            end
            HOLD:  begin
                state_d = CHECK;
                err_d   = |((q_in ^ d_q) & m_q);
            end
            default: state_d = IDLE;
        endcase
        // outputs are registered, so they are decoded from the state being entered
        drive   = state_d inside {SETUP, PULSE, HOLD};
        ready_d = state_d == IDLE;
        e_d     = state_d == PULSE;
        done_d  = state_d == CHECK;
        s_d     = drive ? (d_d & m_d) : '0;
        r_d     = drive ? (~d_d & m_d) : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            m_q     <= '0;
            s_q     <= '0;
            r_q     <= '0;
            ready_q <= 1'b1;
            e_q     <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            m_q     <= m_d;
            s_q     <= s_d;
            r_q     <= r_d;
            ready_q <= ready_d;
            e_q     <= e_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    assign ready = ready_q;
    assign S     = s_q;
    assign R     = r_q;
    assign E     = e_q;
    assign done  = done_q;
    assign err   = err_q;
endmodule

// File: doc/sr_latch_writer.md
# sr_latch_writer

Synchronous write controller for a bank of WIDTH gated SR latches. It accepts a word on a req/ready handshake and drives per-bit S/R with a gated enable pulse of programmable length, honouring a per-bit write mask. It then reads the latch Q outputs back and flags any mismatch. It sits between clocked logic and the latch bank: the clocked logic writes, and the latch bank stores.

## Interface
- WIDTH, 8: number of latches driven; range 1..32.
- E_PULSE, 2: number of cycles E is held high per write; range 1..15.

- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  1  write request; sampled only when ready=1.
- wdata  input  WIDTH  word to store; captured on acceptance.
- wmask  input  WIDTH  per-bit write enable; captured on acceptance; 0 = leave latch untouched.
- ready  output  1  high in IDLE; request accepted on an edge where req=1 and ready=1.
- S  output  WIDTH  per-bit set drive to latch bank.
- R  output  WIDTH  per-bit reset drive to latch bank.
- E  output  1  latch gate enable.
- q_in  input  WIDTH  Q read-back from latch bank.
- done  output  1  one-cycle pulse at the end of every write.
- err  output  1  valid when done=1: 1 if any masked-in bit of q_in differs from the captured wdata.

## Operation
- All outputs are registered.
- Reset values: ready=1, S=0, R=0, E=0, done=0, err=0, and the FSM is in IDLE.
- FSM states: IDLE, SETUP, PULSE, HOLD, CHECK.
- IDLE: ready=1, S=R=0, E=0. On req=1 the block captures wdata into d and wmask into m, then moves to SETUP.
- SETUP (1 cycle): for each bit, S=d&m and R=~d&m. E=0 and ready=0. Data is set up before the gate opens.
- PULSE (E_PULSE cycles): E=1 and S/R are unchanged. A 4-bit down-counter is loaded with E_PULSE-1 on entry. The FSM leaves PULSE when the counter is 0.
- HOLD (1 cycle): E=0 and S/R are still driven, giving hold time after the gate closes. At the end of HOLD, q_in is sampled and compared with d on bits where m=1.
- CHECK (1 cycle): S=R=0, done=1, err=compare result. The FSM then returns to IDLE.
- Invariant: S[i]&R[i] is never 1 for any bit, in any state or cycle.
- Masked-out bits (m[i]=0) have S[i]=R[i]=0 throughout the write and are excluded from the compare.
- wmask=0 is legal. The full sequence still runs with E pulsed, and err=0.
- req while ready=0 is ignored. It is not queued.
- Changes to wdata/wmask after acceptance have no effect on the current write.

## Timing
- Let cycle 0 be the cycle after the acceptance edge.
- Cycle 0 is SETUP.
- Cycles 1..E_PULSE are PULSE, with E=1.
- Cycle E_PULSE+1 is HOLD.
- Cycle E_PULSE+2 is CHECK, with done=1.
- Cycle E_PULSE+3 is IDLE, with ready=1.
- Total write occupancy is E_PULSE+3 cycles.
- Back-to-back writes: with req held high, the next acceptance happens on the first IDLE edge. Minimum spacing between done pulses is E_PULSE+4 cycles.
- q_in is sampled only on the edge that ends HOLD. Glitches on q_in in other cycles do not affect err.
- Reset asserted mid-write (any state): on the next edge E=0, S=R=0, done=0, err=0, ready=1, and the FSM is in IDLE. The aborted write never produces done.
- Reset and req on the same edge: reset wins and the request is dropped.
- done=1 and err=1 in CHECK do not block the return to IDLE. err returns to 0 the cycle after CHECK.

## Test plan
- Reset, then idle: S=R=0, E=0, ready=1, done=0 for 10 cycles regardless of req/wdata toggling during rst=1.
- WIDTH=8, E_PULSE=2, wdata=8'hA5, wmask=8'hFF, q_in mirrors the latch model:
  - S=8'hA5 and R=8'h5A from cycle 0 to cycle 3.
  - E=1 in cycles 1-2.
  - done in cycle 4 with err=0.
  - ready back in cycle 5.
- Masked write: wdata=8'hFF, wmask=8'h0F. Expect S=8'h0F and R=8'h00. A model with q_in upper nibble 0 gives err=0.
- Read-back fault: force q_in bit 3 stuck at 0 and write wdata=8'h08 with wmask=8'hFF. Expect done=1 with err=1.
- Busy and reset:
  - A req pulse during PULSE is ignored; exactly one done is produced.
  - A second write asserts rst in PULSE. Expect E=0, S=R=0, ready=1 on the next edge, and no done.
- Check the invariant S&R==0 and E_PULSE=1 and E_PULSE=15 (occupancy 4 and 18 cycles) on every cycle of a randomized 500-write run.
